// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states
// and flag bit positions in the {overflow, sign, carry} response field.
package alu_arbiter_pkg;

   localparam logic [3:0] OPC_ADD = 4'b0100;
   localparam logic [3:0] OPC_SUB = 4'b0101;
   localparam logic [3:0] OPC_SHL = 4'b0110;
   localparam logic [3:0] OPC_SHR = 4'b0111;

   localparam int FLAG_OV    = 2;
   localparam int FLAG_SIGN  = 1;
   localparam int FLAG_CARRY = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXEC    = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   function automatic logic [2:0] pack_flags(input logic ov, input logic sign, input logic carry);
      logic [2:0] f;
      f             = '0;
      f[FLAG_OV]    = ov;
      f[FLAG_SIGN]  = sign;
      f[FLAG_CARRY] = carry;
      return f;
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. The last winner loses the next tie; last_grant
// only moves when a grant is actually issued (en high).
module rr_arbiter2 (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req0,
   input  logic req1,
   output logic grant0,
   output logic grant1
);

   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      grant0       = en & req0 & ~(req1 & ~last_grant_q);
      grant1       = en & req1 & ~grant0;
      last_grant_d = last_grant_q;
      if (grant0) begin
         last_grant_d = 1'b0;
      end else if (grant1) begin
         last_grant_d = 1'b1;
      end
   end

   // Reset to 1 so requester 0 wins the first conflict.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two valid/ready requesters. One op is in
// flight at a time: accept, drive ALU for one cycle, capture, hold response.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int OPC_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OPC_W-1:0]  req0_opcode,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic [2:0]        rsp0_flags,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OPC_W-1:0]  req1_opcode,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic [2:0]        rsp1_flags,
   output logic [OPC_W-1:0]  alu_opcode,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry,
   input  logic              alu_sign,
   input  logic              alu_overflow,
   output logic              busy
);

   state_t              state_q;
   logic                owner_q;
   logic [OPC_W-1:0]    alu_opcode_q;
   logic [DATA_W-1:0]   alu_a_q;
   logic [DATA_W-1:0]   alu_b_q;
   logic [1:0]          rsp_valid_q;
   logic [DATA_W-1:0]   rsp_result_q [2];
   logic [2:0]          rsp_flags_q  [2];

   logic                grant0;
   logic                grant1;
   logic [1:0]          rsp_ready_w;

   assign rsp_ready_w = {rsp1_ready, rsp0_ready};

   rr_arbiter2 u_rr (
      .clk    (clk),
      .rst    (rst),
      .en     (state_q == IDLE),
      .req0   (req0_valid),
      .req1   (req1_valid),
      .grant0 (grant0),
      .grant1 (grant1)
   );

   // Grants are already qualified by IDLE, so a grant is an accept.
   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         owner_q         <= 1'b0;
         alu_opcode_q    <= '0;
         alu_a_q         <= '0;
         alu_b_q         <= '0;
         rsp_valid_q     <= '0;
         rsp_result_q[0] <= '0;
         rsp_result_q[1] <= '0;
         rsp_flags_q[0]  <= '0;
         rsp_flags_q[1]  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant0 | grant1) begin
                  owner_q      <= grant1;
                  alu_opcode_q <= grant1 ? req1_opcode : req0_opcode;
                  alu_a_q      <= grant1 ? req1_a : req0_a;
                  alu_b_q      <= grant1 ? req1_b : req0_b;
                  state_q      <= EXEC;
               end
            end
            EXEC: begin
               // ALU samples the operands at the end of this cycle; park it on a zero op afterwards.
               alu_opcode_q <= '0;
               alu_a_q      <= '0;
               alu_b_q      <= '0;
               state_q      <= CAPTURE;
            end
            CAPTURE: begin
               rsp_result_q[owner_q] <= alu_result;
               rsp_flags_q[owner_q]  <= pack_flags(alu_overflow, alu_sign, alu_carry);
               rsp_valid_q[owner_q]  <= 1'b1;
               state_q               <= RESP;
            end
            RESP: begin
               if (rsp_ready_w[owner_q]) begin
                  rsp_valid_q[owner_q]  <= 1'b0;
                  rsp_result_q[owner_q] <= '0;
                  rsp_flags_q[owner_q]  <= '0;
                  state_q               <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign alu_opcode  = alu_opcode_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign rsp0_valid  = rsp_valid_q[0];
   assign rsp1_valid  = rsp_valid_q[1];
   assign rsp0_result = rsp_result_q[0];
   assign rsp1_result = rsp_result_q[1];
   assign rsp0_flags  = rsp_flags_q[0];
   assign rsp1_flags  = rsp_flags_q[1];
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a registered ALU model
// attached; a negedge monitor checks grants, busy and every response cycle.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]  req0_opcode, req1_opcode;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [15:0] rsp0_result, rsp1_result;
   logic [2:0]  rsp0_flags, rsp1_flags;
   logic [3:0]  alu_opcode;
   logic [15:0] alu_a, alu_b, alu_result;
   logic        alu_carry, alu_sign, alu_overflow, busy;

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(16), .OPC_W(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_a(req0_a), .req0_b(req0_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_overflow(alu_overflow),
      .busy(busy)
   );

   // Registered ALU attached to the arbiter.
   logic [16:0] alu_w;
   logic        alu_ov_w;
   always_comb begin
      alu_w    = '0;
      alu_ov_w = 1'b0;
      case (alu_opcode)
         OPC_ADD: begin
            alu_w    = {1'b0, alu_a} + {1'b0, alu_b};
            alu_ov_w = (alu_a[15] == alu_b[15]) && (alu_w[15] != alu_a[15]);
         end
         OPC_SUB: begin
            alu_w    = {1'b0, alu_a} - {1'b0, alu_b};
            alu_ov_w = (alu_a[15] != alu_b[15]) && (alu_w[15] != alu_a[15]);
         end
         OPC_SHL: alu_w = {alu_a, 1'b0};
         OPC_SHR: alu_w = {alu_a[0], 1'b0, alu_a[15:1]};
         default: alu_w = '0;
      endcase
   end
   always_ff @(posedge clk) begin
      alu_result   <= alu_w[15:0];
      alu_carry    <= alu_w[16];
      alu_sign     <= alu_w[15];
      alu_overflow <= alu_ov_w;
   end

   typedef struct {
      bit          owner;
      logic [15:0] res;
      logic [2:0]  flg;
      int          acc;
   } exp_t;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cycle    = 0;
   int   pct0     = 100;
   int   pct1     = 100;
   bit   m_idle   = 1'b1;
   bit   m_last   = 1'b1;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
      end
   endtask

   // Reference ALU from plain integer arithmetic on the operand values.
   function automatic void ref_alu(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] res, output logic [2:0] flg);
      int ua, ub, sa, sb, t;
      bit c, ov;
      ua = a; ub = b; sa = $signed(a); sb = $signed(b);
      t = 0; c = 0; ov = 0;
      case (opc)
         OPC_ADD: begin t = ua + ub; c = (t > 65535); ov = (sa + sb > 32767) || (sa + sb < -32768); end
         OPC_SUB: begin t = ua - ub; c = (ua < ub);   ov = (sa - sb > 32767) || (sa - sb < -32768); end
         OPC_SHL: begin t = ua * 2;  c = (ua >= 32768); end
         OPC_SHR: begin t = ua / 2;  c = (ua % 2) == 1; end
         default: t = 0;
      endcase
      res = t[15:0];
      flg = {ov, res[15], c};
   endfunction

   // Monitor: grant model, busy, and scoreboard of responses.
   always @(negedge clk) begin
      bit          e_r0, e_r1, popped;
      logic        vld, rdy;
      logic [15:0] res;
      logic [2:0]  flg;
      exp_t        e;
      if (rst) begin
         sbq.delete();
         m_idle = 1'b1;
         m_last = 1'b1;
      end else begin
         popped = 1'b0;
         check("busy", busy, !m_idle);
         e_r0 = m_idle && req0_valid && !(req1_valid && m_last == 1'b0);
         e_r1 = m_idle && req1_valid && !e_r0;
         check("req0_ready", req0_ready, e_r0);
         check("req1_ready", req1_ready, e_r1);
         for (int r = 0; r < 2; r++) begin
            vld = r ? rsp1_valid : rsp0_valid;
            rdy = r ? rsp1_ready : rsp0_ready;
            res = r ? rsp1_result : rsp0_result;
            flg = r ? rsp1_flags : rsp0_flags;
            if (sbq.size() > 0 && sbq[0].owner == r[0] && cycle >= sbq[0].acc + 3) begin
               check($sformatf("rsp%0d_valid", r), vld, 1);
               check($sformatf("rsp%0d_result", r), res, sbq[0].res);
               check($sformatf("rsp%0d_flags", r), flg, sbq[0].flg);
               if (vld && rdy) begin
                  $display("rsp%0d result=%h flags=%b latency=3 done at cycle %0d", r, res, flg, cycle);
                  void'(sbq.pop_front());
                  popped = 1'b1;
               end
            end else if (vld || res != 0 || flg != 0) begin
               check($sformatf("rsp%0d_idle", r), {vld, res, flg}, 0);
            end
         end
         if (e_r0 || e_r1) begin
            e.owner = e_r1;
            e.acc   = cycle;
            if (e_r1) ref_alu(req1_opcode, req1_a, req1_b, e.res, e.flg);
            else      ref_alu(req0_opcode, req0_a, req0_b, e.res, e.flg);
            sbq.push_back(e);
            m_idle = 1'b0;
            m_last = e_r1;
         end
         if (popped) m_idle = 1'b1;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rsp0_ready = ($urandom_range(0, 99) < pct0);
         rsp1_ready = ($urandom_range(0, 99) < pct1);
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic v, input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b);
      if (r == 0) begin req0_valid = v; req0_opcode = opc; req0_a = a; req0_b = b; end
      else        begin req1_valid = v; req1_opcode = opc; req1_a = a; req1_b = b; end
   endtask

   // Call at posedge+1; returns at posedge+1 after the accept or the give-up.
   task automatic issue(input int r, input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                        input int max_wait, input bit must);
      bit taken;
      taken = 1'b0;
      set_req(r, 1'b1, opc, a, b);
      for (int i = 0; i < max_wait && !taken; i++) begin
         @(negedge clk);
         taken = (r == 0) ? req0_ready : req1_ready;
         @(posedge clk);
         #1;
      end
      set_req(r, 1'b0, opc, a, b);
      if (must && !taken) check($sformatf("req%0d_timeout", r), 0, 1);
   endtask

   task automatic drain();
      int i;
      i = 0;
      while ((busy || sbq.size() > 0) && i < 300) begin
         @(posedge clk);
         i++;
      end
      #1;
      if (busy || sbq.size() > 0) check("drain_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   function automatic logic [15:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 16'h7FFF;
         1: return 16'h8000;
         2: return 16'hFFFF;
         3: return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [3:0] rnd_opc();
      logic [3:0] tbl [5];
      tbl = '{OPC_ADD, OPC_SUB, OPC_SHL, OPC_SHR, 4'b0000};
      return tbl[$urandom_range(0, 4)];
   endfunction

   task automatic rnd_stream(input int r, input int n);
      for (int k = 0; k < n; k++) begin
         wait_cycles($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) issue(r, rnd_opc(), rnd_operand(), rnd_operand(), 1, 1'b0);
         else                            issue(r, rnd_opc(), rnd_operand(), rnd_operand(), 200, 1'b1);
      end
   endtask

   initial begin
      rst = 1'b1;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      set_req(0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, '0, '0, '0);
      wait_cycles(3);
      rst = 1'b0;
      wait_cycles(1);

      issue(0, OPC_ADD, 16'd5, 16'd3, 20, 1'b1);
      drain();
      issue(1, OPC_ADD, 16'h7FFF, 16'h0001, 20, 1'b1);
      drain();

      do_reset();
      fork
         issue(0, OPC_ADD, 16'd1, 16'd1, 40, 1'b1);
         issue(1, OPC_SUB, 16'd10, 16'd4, 40, 1'b1);
      join
      for (int p = 0; p < 4; p++) begin
         fork
            issue(0, rnd_opc(), rnd_operand(), rnd_operand(), 40, 1'b1);
            issue(1, rnd_opc(), rnd_operand(), rnd_operand(), 40, 1'b1);
         join
      end
      drain();

      pct0 = 0;
      fork
         issue(0, OPC_SUB, 16'd3, 16'd9, 20, 1'b1);
         begin wait_cycles(1); issue(1, OPC_SHL, 16'hC001, 16'd0, 60, 1'b1); end
         begin
            for (int i = 0; i < 20 && !rsp0_valid; i++) @(negedge clk);
            check("bp_rsp0_seen", rsp0_valid, 1);
            wait_cycles(5);
            pct0 = 100;
         end
      join
      drain();

      issue(0, OPC_SHR, 16'h0003, 16'd0, 20, 1'b1);
      wait_cycles(1);
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      wait_cycles(8);

      issue(1, OPC_ADD, 16'h1234, 16'h1111, 20, 1'b1);
      issue(0, OPC_ADD, 16'h0001, 16'h0001, 1, 1'b0);
      drain();
      wait_cycles(4);

      pct0 = 60; pct1 = 40;
      fork
         rnd_stream(0, 120);
         rnd_stream(1, 120);
      join
      pct0 = 100; pct1 = 100;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
